// File: rtl/counter_year_bcd_pkg.sv
// Shared constants for the BCD year counter.
//   BCD_MAX   : largest legal BCD digit value
//   DIGIT_W   : width of one BCD digit
//   SEG_W     : width of one 7-segment code
//   SEG_TABLE : 7-segment codes, active-low, bit order {g,f,e,d,c,b,a}
//   mod4_zero : (2*hi + lo) mod 4 == 0, the BCD form of "two-digit value divisible by 4"
package counter_year_bcd_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    // Codes 10..15 never occur on a legal digit; they blank the display.
    localparam logic [SEG_W-1:0] SEG_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
        7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

    // 10*hi + lo is congruent to 2*hi + lo modulo 4, so a 5-bit add suffices.
    function automatic logic mod4_zero(input logic [DIGIT_W-1:0] hi,
                                       input logic [DIGIT_W-1:0] lo);
        logic [DIGIT_W:0] sum;
        sum = {hi, 1'b0} + {1'b0, lo};
        return (sum[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/counter_year_bcd_digit.sv
// counter_bcd_digit: one up/down BCD digit of a cascaded counter.
//   clk, reset_n : clock and synchronous active-low reset
//   en           : step this cycle (carry/borrow from the lower digit)
//   dir          : 1 = up, 0 = down
//   load         : take load_val this cycle (overrides en)
//   load_val     : value to load, already clamped to 0..9
//   q            : registered digit
//   q_next       : value q takes at the next edge (ignoring reset)
//   co           : carry (up, q=9) or borrow (down, q=0) into the next digit
module counter_bcd_digit
    import counter_year_bcd_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               dir,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] q,
    output logic [DIGIT_W-1:0] q_next,
    output logic               co
);

    logic terminal;

    always_comb begin
        terminal = dir ? (q == BCD_MAX) : (q == '0);
        co       = en & ~load & terminal;
        if (load) begin
            q_next = load_val;
        end else if (en) begin
            if (dir) begin
                q_next = terminal ? '0 : q + 4'd1;
            end else begin
                q_next = terminal ? BCD_MAX : q - 4'd1;
            end
        end else begin
            q_next = q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/counter_year_bcd_led7.sv
// Led7thanh: 7-segment decoder for one BCD digit (active-low segments).
//   bcd : input digit, 0..9
//   seg : segment code {g,f,e,d,c,b,a}
module Led7thanh
    import counter_year_bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output logic [SEG_W-1:0]   seg
);

    always_comb begin
        seg = SEG_TABLE[bcd];
    end

endmodule

// File: rtl/counter_year_bcd.sv
// counter_year_bcd: BCD year counter with leap-year flag and 7-segment outputs.
//   clk, reset_n : clock and synchronous active-low reset
//   cy1          : count enable (carry from the month stage)
//   dir          : 1 = up, 0 = down
//   load         : load load_bcd this cycle (digits > 9 clamped to 9)
//   load_bcd     : packed BCD load value, units in [3:0]
//   bcd_out      : packed BCD count, units in [3:0]
//   seg_out      : 7-segment codes, units in [6:0]
//   leap_year    : BASE_YEAR + count is a Gregorian leap year (registered)
//   wrap         : one-cycle pulse after the count wraps 999..->0 or 0->999..
//   load_err     : one-cycle pulse after a load that needed clamping
module counter_year_bcd
    import counter_year_bcd_pkg::*;
#(
    parameter int unsigned DIGITS    = 3,
    parameter int unsigned BASE_YEAR = 2000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cy1,
    input  logic                    dir,
    input  logic                    load,
    input  logic [4*DIGITS-1:0]     load_bcd,
    output logic [4*DIGITS-1:0]     bcd_out,
    output logic [7*DIGITS-1:0]     seg_out,
    output logic                    leap_year,
    output logic                    wrap,
    output logic                    load_err
);

    if (DIGITS < 2 || DIGITS > 4 || (BASE_YEAR % 400) != 0) begin : g_bad_param
        $error("counter_year_bcd: DIGITS must be 2..4 and BASE_YEAR a multiple of 400");
    end

    logic [DIGITS-1:0]  en;
    logic [DIGITS-1:0]  co;
    logic [DIGITS-1:0]  over;
    logic [DIGIT_W-1:0] clamp [DIGITS];
    logic [DIGIT_W-1:0] q     [DIGITS];
    logic [DIGIT_W-1:0] nxt   [DIGITS];
    logic [DIGIT_W-1:0] hund;
    logic [DIGIT_W-1:0] thou;
    logic               leap_next;

    always_comb begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
            over[i]  = load_bcd[4*i +: 4] > BCD_MAX;
            clamp[i] = over[i] ? BCD_MAX : load_bcd[4*i +: 4];
        end
    end

    // Ripple enable: a digit steps only when every lower digit carries/borrows.
    assign en[0] = cy1 & ~load;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i > 0) begin : g_chain
            assign en[i] = co[i-1];
        end

        counter_bcd_digit u_digit (
            .clk      (clk),
            .reset_n  (reset_n),
            .en       (en[i]),
            .dir      (dir),
            .load     (load),
            .load_val (clamp[i]),
            .q        (q[i]),
            .q_next   (nxt[i]),
            .co       (co[i])
        );

        Led7thanh u_seg (
            .bcd (q[i]),
            .seg (seg_out[7*i +: 7])
        );

        assign bcd_out[4*i +: 4] = q[i];
    end

    if (DIGITS >= 3) begin : g_hund
        assign hund = nxt[2];
    end else begin : g_no_hund
        assign hund = '0;
    end

    if (DIGITS >= 4) begin : g_thou
        assign thou = nxt[3];
    end else begin : g_no_thou
        assign thou = '0;
    end

    // Leap flag is computed from the next-state digits so it lands on the
    // same edge as the count it describes.
    always_comb begin
        leap_next = mod4_zero(nxt[1], nxt[0]) &
                    ((nxt[0] != '0) | (nxt[1] != '0) | mod4_zero(thou, hund));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            leap_year <= 1'b1;
            wrap      <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            leap_year <= leap_next;
            wrap      <= co[DIGITS-1];
            load_err  <= load & (|over);
        end
    end

endmodule

// File: tb/tb_counter_year_bcd.sv
module tb_counter_year_bcd;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cy1;
    logic        dir;
    logic        load;
    logic [11:0] load_bcd;
    logic [11:0] bcd_out;
    logic [20:0] seg_out;
    logic        leap_year;
    logic        wrap;
    logic        load_err;

    int checks   = 0;
    int failures = 0;

    counter_year_bcd #(.DIGITS(3), .BASE_YEAR(2000)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cy1       (cy1),
        .dir       (dir),
        .load      (load),
        .load_bcd  (load_bcd),
        .bcd_out   (bcd_out),
        .seg_out   (seg_out),
        .leap_year (leap_year),
        .wrap      (wrap),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rn;
        logic        cy;
        logic        dr;
        logic        ld;
        logic [11:0] lv;
        logic [11:0] eb;
        logic        el;
        logic        ew;
        logic        ee;
    } vec_t;

    logic [6:0] seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [20:0] seg_of(input logic [11:0] b);
        return {seg_ref[b[11:8]], seg_ref[b[7:4]], seg_ref[b[3:0]]};
    endfunction

    task automatic cycle(input logic rn, input logic cy, input logic dr,
                         input logic ld, input logic [11:0] lv);
        @(negedge clk);
        reset_n  = rn;
        cy1      = cy;
        dir      = dr;
        load     = ld;
        load_bcd = lv;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        reset_n  = 1'b0;
        cy1      = 1'b0;
        dir      = 1'b1;
        load     = 1'b0;
        load_bcd = '0;

        //                 rn  cy  dr  ld  load    bcd     leap wrap err
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0,12'h000,12'h000,1'b1,1'b0,1'b0}); // reset
        vecs.push_back('{1'b1,1'b0,1'b1,1'b0,12'h000,12'h000,1'b1,1'b0,1'b0}); // idle
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,12'h555,12'h000,1'b1,1'b0,1'b0}); // idle
        vecs.push_back('{1'b1,1'b0,1'b1,1'b1,12'h099,12'h099,1'b0,1'b0,1'b0}); // load 2099
        vecs.push_back('{1'b1,1'b1,1'b1,1'b0,12'h000,12'h100,1'b0,1'b0,1'b0}); // 2100
        vecs.push_back('{1'b1,1'b1,1'b1,1'b0,12'h000,12'h101,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b0,12'h000,12'h102,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b0,12'h000,12'h103,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b0,12'h000,12'h104,1'b1,1'b0,1'b0}); // 2104
        vecs.push_back('{1'b1,1'b0,1'b1,1'b0,12'h000,12'h104,1'b1,1'b0,1'b0}); // hold
        vecs.push_back('{1'b1,1'b0,1'b1,1'b1,12'h999,12'h999,1'b0,1'b0,1'b0}); // load 2999
        vecs.push_back('{1'b1,1'b1,1'b1,1'b0,12'h000,12'h000,1'b1,1'b1,1'b0}); // wrap up
        vecs.push_back('{1'b1,1'b0,1'b1,1'b0,12'h000,12'h000,1'b1,1'b0,1'b0}); // wrap drops
        vecs.push_back('{1'b1,1'b1,1'b0,1'b0,12'h000,12'h999,1'b0,1'b1,1'b0}); // wrap down
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,12'h000,12'h999,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b1,1'b1,12'h3A0,12'h390,1'b0,1'b0,1'b1}); // clamp
        vecs.push_back('{1'b1,1'b0,1'b1,1'b0,12'h000,12'h390,1'b0,1'b0,1'b0}); // err drops
        vecs.push_back('{1'b1,1'b0,1'b1,1'b1,12'h400,12'h400,1'b1,1'b0,1'b0}); // 2400
        vecs.push_back('{1'b1,1'b1,1'b1,1'b1,12'h09F,12'h099,1'b0,1'b0,1'b1}); // load wins
        vecs.push_back('{1'b1,1'b1,1'b0,1'b1,12'h123,12'h123,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,1'b0,12'h000,12'h122,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,1'b0,12'h000,12'h121,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,1'b0,12'h000,12'h120,1'b1,1'b0,1'b0}); // 2120
        vecs.push_back('{1'b0,1'b1,1'b1,1'b1,12'h777,12'h000,1'b1,1'b0,1'b0}); // reset wins
        vecs.push_back('{1'b1,1'b1,1'b1,1'b0,12'h000,12'h001,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,1'b0,12'h000,12'h000,1'b1,1'b0,1'b0}); // no wrap
        vecs.push_back('{1'b1,1'b0,1'b0,1'b1,12'hFFF,12'h999,1'b0,1'b0,1'b1}); // all clamp
        vecs.push_back('{1'b1,1'b1,1'b0,1'b0,12'h000,12'h998,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b0,12'h000,12'h999,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b0,12'h000,12'h000,1'b1,1'b1,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b0,12'h000,12'h001,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0,12'h000,12'h000,1'b1,1'b0,1'b0}); // mid-count reset

        foreach (vecs[k]) begin
            cycle(vecs[k].rn, vecs[k].cy, vecs[k].dr, vecs[k].ld, vecs[k].lv);
            chk($sformatf("vec%0d bcd_out", k), 32'(bcd_out), 32'(vecs[k].eb));
            chk($sformatf("vec%0d leap_year", k), 32'(leap_year), 32'(vecs[k].el));
            chk($sformatf("vec%0d wrap", k), 32'(wrap), 32'(vecs[k].ew));
            chk($sformatf("vec%0d load_err", k), 32'(load_err), 32'(vecs[k].ee));
            chk($sformatf("vec%0d seg_out", k), 32'(seg_out), 32'(seg_of(vecs[k].eb)));
        end

        // Held idle over several cycles after a load: nothing may move.
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 12'h567);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, i[0], 1'b0, 12'h321);
            chk("hold bcd_out", 32'(bcd_out), 32'h567);
            chk("hold flags", {29'd0, leap_year, wrap, load_err}, 32'd0);
        end

        // Full up sweep against the mod-4/100/400 rule.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        chk("sweep start", 32'(bcd_out), 32'h000);
        begin
            int          n;
            int          y;
            logic        exp_leap;
            logic [11:0] exp_bcd;
            n = 0;
            for (int s = 0; s < 1000; s++) begin
                cycle(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
                n = (n + 1) % 1000;
                y = 2000 + n;
                exp_leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
                exp_bcd  = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
                chk($sformatf("sweep%0d leap_year", n), 32'(leap_year), 32'(exp_leap));
                chk($sformatf("sweep%0d bcd_out", n), 32'(bcd_out), 32'(exp_bcd));
                chk($sformatf("sweep%0d wrap", n), 32'(wrap), 32'(n == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
